// File: rtl/relu_backprop_delta_pkg.sv
// Shared definitions for the ReLU backprop delta block and its FP16 multiplier.
//   - FP16 field widths, bias and the special encodings used by the datapath
//   - FSM state encoding for the vector controller
//   - stage register structs for the 3-stage FP16 multiplier
package relu_backprop_delta_pkg;

   localparam int EXP_W    = 5;
   localparam int MAN_W    = 10;
   localparam int EXP_BIAS = 15;

   localparam logic [15:0] FP16_ONE     = 16'h3C00;
   localparam logic [15:0] FP16_POS_INF = 16'h7C00;
   localparam logic [15:0] FP16_QNAN    = 16'h7E00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Operand classification is folded into three mutually exclusive result
   // flags; when none is set the significand product decides the result.
   typedef struct packed {
      logic                sign;
      logic                nan;
      logic                inf;
      logic                zero;
      logic [6:0]          exp;   // ea+eb-bias, two's complement
      logic [MAN_W:0]      ma;    // hidden 1 included
      logic [MAN_W:0]      mb;
   } s1_t;

   typedef struct packed {
      logic                sign;
      logic                nan;
      logic                inf;
      logic                zero;
      logic [6:0]          exp;
      logic [2*MAN_W+1:0]  prod;
   } s2_t;

endpackage

// File: rtl/relu_backprop_delta_mul.sv
// fp16_mul_pipe: general 3-stage IEEE binary16 multiplier.
//   clk, rst_n : clock, async active-low reset (clears stage contents)
//   en         : stage enable; all stages shift together when high
//   vin, a, b  : input valid and operands
//   y, vout    : registered product and its valid
// Stage 1 classifies/unpacks, stage 2 multiplies significands, stage 3
// normalizes, rounds to nearest-even and packs. Subnormals flush to zero,
// both on input and on output.
module fp16_mul_pipe
   import relu_backprop_delta_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        vin,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] y,
   output logic        vout
);

   localparam int STAGES = 3;

   s1_t               s1_d, s1_q;
   s2_t               s2_d, s2_q;
   logic [15:0]       y_d, y_q;
   logic [STAGES:1]   vld_pipe_d, vld_pipe_q;

   // ---------------- stage 1: classify + exponent sum ----------------
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

   always_comb begin
      ea     = a[MAN_W +: EXP_W];
      eb     = b[MAN_W +: EXP_W];
      fa     = a[MAN_W-1:0];
      fb     = b[MAN_W-1:0];
      a_nan  = (&ea) && (|fa);
      b_nan  = (&eb) && (|fb);
      a_inf  = (&ea) && !(|fa);
      b_inf  = (&eb) && !(|fb);
      // exponent field 0 covers both true zero and flushed subnormals
      a_zero = (ea == '0);
      b_zero = (eb == '0);

      s1_d      = '0;
      s1_d.sign = a[15] ^ b[15];
      s1_d.nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
      s1_d.inf  = (a_inf | b_inf) & ~s1_d.nan;
      s1_d.zero = (a_zero | b_zero) & ~s1_d.nan & ~s1_d.inf;
      s1_d.exp  = 7'(ea) + 7'(eb) - 7'(EXP_BIAS);
      s1_d.ma   = {1'b1, fa};
      s1_d.mb   = {1'b1, fb};
   end

   // ---------------- stage 2: significand product ----------------
   always_comb begin
      s2_d      = '0;
      s2_d.sign = s1_q.sign;
      s2_d.nan  = s1_q.nan;
      s2_d.inf  = s1_q.inf;
      s2_d.zero = s1_q.zero;
      s2_d.exp  = s1_q.exp;
      s2_d.prod = (2*MAN_W+2)'(s1_q.ma) * (2*MAN_W+2)'(s1_q.mb);
   end

   // ---------------- stage 3: normalize, round, pack ----------------
   logic signed [7:0] e_n, e_r;
   logic [MAN_W-1:0]  man;
   logic [MAN_W:0]    man_r;
   logic              g, s, rnd;

   always_comb begin
      e_n = $signed({s2_q.exp[6], s2_q.exp});
      if (s2_q.prod[2*MAN_W+1]) begin
         // product in [2,4): shift right one, bump exponent
         man = s2_q.prod[2*MAN_W   -: MAN_W];
         g   = s2_q.prod[MAN_W];
         s   = |s2_q.prod[MAN_W-1:0];
         e_n = e_n + 8'sd1;
      end else begin
         man = s2_q.prod[2*MAN_W-1 -: MAN_W];
         g   = s2_q.prod[MAN_W-1];
         s   = |s2_q.prod[MAN_W-2:0];
      end
      rnd   = g & (s | man[0]);
      man_r = {1'b0, man} + (MAN_W+1)'(rnd);
      // carry out of the mantissa leaves man_r[9:0] == 0, i.e. 1.0 x 2^(e+1)
      e_r   = e_n + (man_r[MAN_W] ? 8'sd1 : 8'sd0);

      if (s2_q.nan)
         y_d = FP16_QNAN;
      else if (s2_q.inf)
         y_d = {s2_q.sign, FP16_POS_INF[14:0]};
      else if (s2_q.zero)
         y_d = {s2_q.sign, 15'h0000};
      else if (e_r >= 8'sd31)
         y_d = {s2_q.sign, FP16_POS_INF[14:0]};
      else if (e_r <= 8'sd0)
         y_d = {s2_q.sign, 15'h0000};
      else
         y_d = {s2_q.sign, e_r[EXP_W-1:0], man_r[MAN_W-1:0]};
   end

   assign vld_pipe_d = {vld_pipe_q[STAGES-1:1], vin};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q       <= '0;
         s2_q       <= '0;
         y_q        <= '0;
         vld_pipe_q <= '0;
      end else if (en) begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         y_q        <= y_d;
         vld_pipe_q <= vld_pipe_d;
      end
   end

   assign y    = y_q;
   assign vout = vld_pipe_q[STAGES];

endmodule

// File: rtl/relu_backprop_delta.sv
// relu_backprop_delta: delta = err x ReLU'(z) over one vector of LEN elements.
//   start              : one-cycle pulse, begins a vector (IDLE only)
//   err_in, prime_in   : FP16 operand pair, qualified by in_valid/in_ready
//   delta_out          : FP16 product, qualified by out_valid/out_ready
//   busy               : vector in progress (RUN or DRAIN)
//   done               : one-cycle pulse after the last result handshakes
// The multiplier stalls as a whole whenever the output is held, so
// input acceptance is gated by the same advance signal.
module relu_backprop_delta
   import relu_backprop_delta_pkg::*;
#(
   parameter int LEN   = 64,
   parameter int CNT_W = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] err_in,
   input  logic [15:0] prime_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] delta_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done
);

   localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

   state_e           state_d, state_q;
   logic [CNT_W-1:0] acc_cnt_d, acc_cnt_q;
   logic [CNT_W-1:0] out_cnt_d, out_cnt_q;
   logic             adv, acc, hs;

   assign adv      = !(out_valid && !out_ready);
   assign in_ready = (state_q == RUN) && (acc_cnt_q < LEN_C) && adv;
   assign acc      = in_valid && in_ready;
   assign hs       = out_valid && out_ready;

   always_comb begin
      state_d   = state_q;
      acc_cnt_d = acc_cnt_q;
      out_cnt_d = out_cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               acc_cnt_d = '0;
               out_cnt_d = '0;
            end
         end
         RUN: begin
            if (acc) acc_cnt_d = acc_cnt_q + CNT_W'(1);
            if (hs)  out_cnt_d = out_cnt_q + CNT_W'(1);
            if (acc_cnt_d == LEN_C) state_d = DRAIN;
         end
         DRAIN: begin
            if (hs) out_cnt_d = out_cnt_q + CNT_W'(1);
            if (out_cnt_d == LEN_C) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_cnt_q <= '0;
         out_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_cnt_q <= acc_cnt_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   fp16_mul_pipe u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .vin   (acc),
      .a     (err_in),
      .b     (prime_in),
      .y     (delta_out),
      .vout  (out_valid)
   );

   assign busy = (state_q == RUN) || (state_q == DRAIN);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_relu_backprop_delta.sv
// Directed bench for relu_backprop_delta with LEN=4: arithmetic vectors,
// FP16 special cases, backpressure, input gaps, ignored start and
// asynchronous reset mid-drain.
module tb_relu_backprop_delta;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] err_in, prime_in;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] delta_out;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;

   relu_backprop_delta #(.LEN(4), .CNT_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .err_in    (err_in),
      .prime_in  (prime_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .delta_out (delta_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int n_out, n_done, last_hs;
   logic lat_en;
   logic [15:0] exp_q[$];
   int          acc_q[$];
   logic [15:0] va[4], vb[4], ve[4];
   logic        hold_v = 1'b0;
   logic [15:0] hold_d = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
      n_chk++;
      if (got !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp_v, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // output monitor: scoreboard order, latency, hold stability, done timing
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_v <= 1'b0;
      end else begin
         if (in_valid && in_ready) acc_q.push_back(cyc);
         if (out_valid && !out_ready) chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
         if (hold_v) begin
            chk("hold_vld", {31'd0, out_valid}, 32'd1);
            chk("hold_data", {16'd0, delta_out}, {16'd0, hold_d});
         end
         hold_v <= out_valid && !out_ready;
         hold_d <= delta_out;
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() > 0) chk("delta", {16'd0, delta_out}, {16'd0, exp_q.pop_front()});
            if (acc_q.size() > 0) begin
               int a_c;
               a_c = acc_q.pop_front();
               if (lat_en) chk("latency", cyc, a_c + 3);
            end
            last_hs = cyc;
         end
         if (done) begin
            n_done++;
            chk("done_lat", cyc, last_hs + 1);
         end
      end
   end

   task automatic set_vec(input logic [15:0] a0, b0, e0, a1, b1, e1,
                          input logic [15:0] a2, b2, e2, a3, b3, e3);
      va[0] = a0; vb[0] = b0; ve[0] = e0;
      va[1] = a1; vb[1] = b1; ve[1] = e1;
      va[2] = a2; vb[2] = b2; ve[2] = e2;
      va[3] = a3; vb[3] = b3; ve[3] = e3;
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_delta"},     {16'd0, delta_out}, 32'd0);
      chk({tag, "_busy"},      {31'd0, busy},      32'd0);
      chk({tag, "_done"},      {31'd0, done},      32'd0);
   endtask

   // gap: toggle in_valid; bp: stall output 5 cycles; ign: extra starts;
   // rst_mid: async reset once in DRAIN instead of completing
   task automatic run_vec(input bit gap, input bit bp, input bit ign, input bit rst_mid);
      exp_q.delete();
      acc_q.delete();
      n_out  = 0;
      n_done = 0;
      lat_en = !bp;
      for (int i = 0; i < 4; i++) exp_q.push_back(ve[i]);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      fork
         begin : feeder
            int idx, t;
            logic a_ok;
            idx = 0; t = 0;
            while (idx < 4 && t < 200) begin
               in_valid = gap ? ((t % 2) == 0) : 1'b1;
               err_in   = va[idx];
               prime_in = vb[idx];
               start    = ign && (idx == 2);
               @(negedge clk);
               a_ok = in_valid && in_ready;
               @(posedge clk); #1;
               if (a_ok) idx++;
               t++;
            end
            in_valid = 1'b0;
            start    = 1'b0;
            chk("feed_count", idx, 4);
         end
         begin : staller
            if (bp) begin
               int t;
               t = 0;
               while (!out_valid && t < 100) begin
                  @(posedge clk); #1;
                  t++;
               end
               chk("bp_seen_valid", {31'd0, out_valid}, 32'd1);
               out_ready = 1'b0;
               repeat (5) @(posedge clk);
               #1 out_ready = 1'b1;
            end
         end
      join
      // now in DRAIN
      chk("drain_busy", {31'd0, busy}, 32'd1);
      chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
      if (rst_mid) begin
         #2 rst_n = 1'b0;
         #1 chk_idle_outs("rst_mid");
         #10 rst_n = 1'b1;
         @(posedge clk); #1;
         chk_idle_outs("post_rst");
      end else begin
         int t;
         if (ign) begin
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
         end
         t = 0;
         while (n_done == 0 && t < 100) begin
            @(posedge clk);
            t++;
         end
         @(negedge clk);
         chk("n_done", n_done, 1);
         chk("n_out", n_out, 4);
         chk("end_busy", {31'd0, busy}, 32'd0);
         chk("end_done", {31'd0, done}, 32'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      err_in = '0; prime_in = '0;
      #1 chk_idle_outs("reset");
      #22 rst_n = 1'b1;
      @(posedge clk); #1 chk_idle_outs("idle");

      // basic arithmetic
      set_vec(16'h4000, 16'h3C00, 16'h4000,  16'hC200, 16'h0000, 16'h8000,
              16'h3E00, 16'h3E00, 16'h4080,  16'h3555, 16'h3C00, 16'h3555);
      run_vec(0, 0, 0, 0);

      // specials: overflow, inf*0, -inf*1, subnormal flush
      set_vec(16'h7BFF, 16'h4000, 16'h7C00,  16'h7C00, 16'h0000, 16'h7E00,
              16'hFC00, 16'h3C00, 16'hFC00,  16'h0001, 16'h3C00, 16'h0000);
      run_vec(0, 0, 0, 0);

      // underflow, identity, NaN, sign; with backpressure and ignored starts
      set_vec(16'h0400, 16'h0400, 16'h0000,  16'h3C00, 16'h3C00, 16'h3C00,
              16'h7C01, 16'h3C00, 16'h7E00,  16'h4200, 16'hC000, 16'hC600);
      run_vec(0, 1, 1, 0);

      // rounding: ties to even (up/down), mantissa carry, carry into inf; gaps
      set_vec(16'h3E00, 16'h3C01, 16'h3E02,  16'h3E00, 16'h3C03, 16'h3E04,
              16'h3FFE, 16'h3C01, 16'h4000,  16'h7BFE, 16'h3C01, 16'h7C00);
      run_vec(1, 0, 0, 0);

      // async reset mid-drain
      set_vec(16'h4000, 16'h3C00, 16'h4000,  16'hC200, 16'h0000, 16'h8000,
              16'h3E00, 16'h3E00, 16'h4080,  16'h3555, 16'h3C00, 16'h3555);
      run_vec(0, 0, 0, 1);

      // fresh vector after reset: exponent exactly 0, sign, NaN, normal
      set_vec(16'h0400, 16'h3800, 16'h0000,  16'h3C00, 16'hC000, 16'hC000,
              16'h7C00, 16'h7E00, 16'h7E00,  16'hC000, 16'hC000, 16'h4400);
      run_vec(0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/relu_backprop_delta.md
Name: relu_backprop_delta

Overview:
Downstream neighbour of the ReLU-derivative stage in the backprop datapath.
- Computes the element-wise FP16 (IEEE binary16) product delta = err × ReLU'(z) over one vector of LEN neurons.
- Consumes the derivative stream (0x0000 or 0x3C00) alongside the propagated error stream.
- Delivers results to the weight-update engine through a valid/ready stream.
- Uses a general 3-stage FP16 multiplier, so it also serves any other FP16 element-wise product.

Parameters:
LEN, 64, number of elements per vector; one start processes exactly LEN products
CNT_W, 7, element counter width; must satisfy 2^CNT_W > LEN

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous assert, active-low
start  in  1  one-cycle pulse; begins a vector; honoured only in IDLE
err_in  in  16  FP16 propagated error
prime_in  in  16  FP16 ReLU derivative
in_valid  in  1  err_in/prime_in valid
in_ready  out  1  block accepts input pair this cycle
delta_out  out  16  FP16 product
out_valid  out  1  delta_out valid
out_ready  in  1  consumer accepts delta_out
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle pulse: last of LEN results handshaken

Behaviour:
- One clock (clk). Reset rst_n is asynchronous and active-low.
- Reset, including mid-vector, clears all state: FSM to IDLE, counters to 0, all stage valids to 0, pipeline contents discarded.
- Output values under reset: in_ready=0, out_valid=0, delta_out=16'h0000, busy=0, done=0.
- Handshakes:
  - Input accepted when in_valid && in_ready.
  - Output transferred when out_valid && out_ready.
  - delta_out is held stable while out_valid && !out_ready.
- Pipeline enable: adv = !(out_valid && !out_ready). All three stages shift only when adv=1, so the pipeline stalls as a whole. Bubbles do not need to be collapsed.
- in_ready = (state==RUN) && (acc_cnt < LEN) && adv.
- Latency: accept at cycle N gives out_valid at cycle N+3 when there is no backpressure. Throughput is 1 per cycle.
- FSM:
  - IDLE: start=1 → RUN; acc_cnt=0, out_cnt=0. A start in any other state is ignored.
  - RUN: acc_cnt increments on each accept. When acc_cnt reaches LEN → DRAIN.
  - DRAIN: in_ready=0; wait for outputs. When out_cnt reaches LEN → DONE.
  - DONE: done=1 for exactly one cycle, then → IDLE.
  - out_cnt increments on each output handshake in RUN or DRAIN.
  - If the LEN-th output handshakes in the same cycle as the LEN-th accept would be impossible (latency ≥3), so DRAIN always occurs for ≥2 cycles.
- FP16 multiply, one function per stage:
  - S1: unpack fields; classify each operand as zero/subnormal/normal/inf/NaN; sign = sa^sb; exponent sum = ea+eb−15 as signed 7-bit.
  - S2: 11×11 significand product, 22 bits, including hidden 1s.
  - S3: normalize; round-to-nearest-even using guard+sticky; pack.
- Special cases:
  - Subnormal inputs are flushed to signed zero before use.
  - NaN input, or inf×0 → canonical 0x7E00.
  - inf×finite-nonzero → signed inf (sign<<15 | 0x7C00).
  - Any zero operand (no inf/NaN) → signed zero (sign<<15).
  - After rounding, exponent ≥31 → signed inf.
  - After rounding, exponent ≤0 → signed zero (no subnormal outputs).
  - Rounding carry-out of the mantissa increments the exponent, then the overflow check is reapplied.
- A derivative of exactly 0x3C00 returns err_in unchanged, except that subnormal err_in flushes to signed zero and NaN becomes 0x7E00.

Decomposition:
- Shared package holds:
  - FP16 constants: FP16_ONE 16'h3C00, FP16_POS_INF 16'h7C00, FP16_QNAN 16'h7E00, EXP_BIAS 15, EXP_W 5, MAN_W 10.
  - FSM state encoding: IDLE/RUN/DRAIN/DONE.
- One sub-module: fp16_mul_pipe.
  - Implements the 3-stage multiplier with ports a, b, en, vin, y, vout.
  - Reusable by the forward MAC datapath.
- The top level keeps the FSM, counters and handshake.

Test Plan:
- LEN=4, start, 4 pairs back-to-back, out_ready=1: (0x4000,0x3C00), (0xC200,0x0000), (0x3E00,0x3E00), (0x3555,0x3C00) → outputs 0x4000, 0x8000, 0x4080, 0x3555 at accept+3; done pulses in the cycle after the 4th output handshake; busy low after.
- Specials: (0x7BFF,0x4000)→0x7C00; (0x7C00,0x0000)→0x7E00; (0xFC00,0x3C00)→0xFC00; (0x0001,0x3C00)→0x0000; (0x0400,0x0400)→0x0000.
- Backpressure: hold out_ready=0 for 5 cycles after the first out_valid → delta_out stable, in_ready=0 while stalled; no loss or duplication; order preserved.
- Gaps: in_valid toggles 1/0 → outputs are spaced identically; out_cnt and done are still correct.
- Ignored start: pulse start during RUN and during DRAIN → no counter reset; exactly LEN outputs.
- Async reset: assert rst_n=0 mid-DRAIN (between clock edges) → all outputs zero immediately; after release, a new start processes a fresh vector correctly.
